// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative EXE-stage divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  // Quotient pattern returned for a zero divisor (sliced to WIDTH by users).
  localparam logic [63:0] DIV0_Q = '1;

  // Magnitude of the low w bits of v; only negates when sgn is set and bit w-1 is 1.
  function automatic logic [63:0] abs_w(input logic [63:0] v, input logic [6:0] w,
                                        input logic sgn);
    logic [63:0] mask;
    logic [5:0]  msb;
    mask = (w >= 7'd64) ? '1 : ((64'd1 << w) - 64'd1);
    msb  = 6'(w - 7'd1);
    if (sgn && v[msb]) abs_w = (~v + 64'd1) & mask;
    else               abs_w = v & mask;
  endfunction

endpackage

// File: rtl/exe_iter_div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < dvs_i always holds, so bit WIDTH of diff is a clean borrow flag.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, dvs_i};
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/exe_iter_div.sv
// Iterative signed/unsigned divider with valid/ready handshakes and flush.
//   state | meaning
//   IDLE  | no operation held; accepts operands
//   CALC  | one restoring step per cycle, MSB first
//   DONE  | result registered and presented until consumed
module exe_iter_div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;

  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             accept;

  assign in_ready = !flush && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  assign dvd_abs = WIDTH'(abs_w(64'(in_dividend), 7'(WIDTH), in_signed));
  assign dvs_abs = WIDTH'(abs_w(64'(in_divisor), 7'(WIDTH), in_signed));

  // Quotient bits shift into the low end of the dividend register as it empties.
  assign quo_d = {dvd_q[WIDTH-2:0], qbit_d};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else if (accept) begin
      dvd_q   <= dvd_abs;
      dvs_q   <= dvs_abs;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= in_signed && (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
      r_neg_q <= in_signed && in_dividend[WIDTH-1];
      if (in_divisor == '0) begin
        state_q   <= DONE;
        quo_out_q <= DIV0_Q[WIDTH-1:0];
        rem_out_q <= in_dividend;
      end else begin
        state_q <= CALC;
      end
    end else begin
      case (state_q)
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q   <= DONE;
            quo_out_q <= q_neg_q ? -quo_d : quo_d;
            rem_out_q <= r_neg_q ? -rem_d : rem_d;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_quotient  = quo_out_q;
  assign out_remainder = rem_out_q;

endmodule

// File: tb/tb_exe_iter_div.sv
// Scoreboard bench for exe_iter_div: a 32-bit and an 8-bit instance checked against plain arithmetic.
module tb_exe_iter_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, in_valid, in_ready, in_signed, flush;
  logic        out_valid, out_ready, busy;
  logic [31:0] in_dividend, in_divisor, out_quotient, out_remainder;

  logic       rst8_n, iv8, ir8, is8, fl8, ov8, or8, busy8;
  logic [7:0] dd8, ds8, oq8, orm8;

  exe_iter_div #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .busy(busy)
  );

  exe_iter_div #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(rst8_n), .in_valid(iv8), .in_ready(ir8),
    .in_signed(is8), .in_dividend(dd8), .in_divisor(ds8),
    .flush(fl8), .out_valid(ov8), .out_ready(or8),
    .out_quotient(oq8), .out_remainder(orm8), .busy(busy8)
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          acc;
    int          lat;
    bit          seen;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_force = 1;  // 0 random, 1 held high, 2 held low
  int   wt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Quotient truncates toward zero, remainder follows the dividend; x/0 gives all ones and x.
  function automatic void ref_div(input int w, input bit sgn, input logic [63:0] a_in,
                                  input logic [63:0] b_in, output logic [63:0] q,
                                  output logic [63:0] r);
    logic [63:0] mask, a, b;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (b == 64'd0) begin
      q = mask;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = '1;
      2:       v = 64'd1 << (w - 1);
      3:       v = 64'($urandom_range(1, 9));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Latency counts edges from the accepting edge to the edge after which out_valid is seen;
  // a zero-divisor result is registered on the accepting edge itself.
  task automatic issue(input bit w8, input bit sgn, input logic [63:0] a, input logic [63:0] b,
                       output int waited);
    exp_t e;
    int   w;
    bit   ok;
    bit   bzero;
    w     = w8 ? 8 : 32;
    bzero = w8 ? (b[7:0] == 8'd0) : (b[31:0] == 32'd0);
    ref_div(w, sgn, a, b, e.q, e.r);
    e.lat  = bzero ? 0 : w;
    e.seen = 1'b0;
    waited = 0;
    ok     = 1'b0;
    @(negedge clk);
    if (w8) begin
      iv8 = 1'b1; is8 = sgn; dd8 = a[7:0]; ds8 = b[7:0];
    end else begin
      in_valid = 1'b1; in_signed = sgn; in_dividend = a[31:0]; in_divisor = b[31:0];
    end
    for (int i = 0; i < 400; i++) begin
      #1;
      if (w8 ? ir8 : in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      e.acc = cyc + 1;
      if (w8) sb8.push_back(e);
      else    sb32.push_back(e);
      @(posedge clk);
    end
    #1;
    if (w8) iv8 = 1'b0;
    else    in_valid = 1'b0;
  endtask

  task automatic drain(input bit w8);
    int pending;
    pending = w8 ? sb8.size() : sb32.size();
    for (int i = 0; i < 300 && pending != 0; i++) begin
      @(negedge clk);
      #3;
      pending = w8 ? sb8.size() : sb32.size();
    end
    chk(w8 ? "drain8" : "drain32", 64'(pending), 64'd0);
  endtask

  initial forever begin
    @(negedge clk);
    out_ready = (rdy_force == 0) ? ($urandom_range(0, 3) != 0) : (rdy_force == 1);
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (resetn && out_valid) begin
      if (sb32.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_valid32: out_valid=1 with nothing pending, required 0");
      end else begin
        if (!sb32[0].seen) begin
          sb32[0].seen = 1'b1;
          chk("latency32", 64'(cyc - sb32[0].acc), 64'(sb32[0].lat));
        end
        chk("quotient32", 64'(out_quotient), sb32[0].q);
        chk("remainder32", 64'(out_remainder), sb32[0].r);
        if (out_ready) void'(sb32.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (rst8_n && ov8) begin
      if (sb8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_valid8: out_valid=1 with nothing pending, required 0");
      end else begin
        if (!sb8[0].seen) begin
          sb8[0].seen = 1'b1;
          chk("latency8", 64'(cyc - sb8[0].acc), 64'(sb8[0].lat));
        end
        chk("quotient8", 64'(oq8), sb8[0].q);
        chk("remainder8", 64'(orm8), sb8[0].r);
        if (or8) void'(sb8.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached before the end of stimulus");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    resetn = 1'b0; in_valid = 1'b0; in_signed = 1'b0; flush = 1'b0;
    in_dividend = '0; in_divisor = '0;
    rst8_n = 1'b0; iv8 = 1'b0; is8 = 1'b0; fl8 = 1'b0; or8 = 1'b1;
    dd8 = '0; ds8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    rst8_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_quotient", 64'(out_quotient), 64'd0);
    chk("rst_remainder", 64'(out_remainder), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid8", 64'(ov8), 64'd0);

    // Directed corner operations.
    rdy_force = 1;
    issue(0, 0, 64'd100, 64'd7, wt);
    issue(0, 1, 64'(-7), 64'd2, wt);
    issue(0, 1, 64'h8000_0000, 64'hFFFF_FFFF, wt);
    issue(0, 0, 64'h1234, 64'd0, wt);
    issue(0, 1, 64'h1234, 64'd0, wt);
    issue(0, 1, 64'(-100), 64'(-7), wt);
    drain(0);

    // Randomised operands with a randomly stalling consumer.
    rdy_force = 0;
    for (int i = 0; i < 60; i++) begin
      issue(0, 1'($urandom_range(0, 1)), rnd_op(32), rnd_op(32), wt);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain(0);

    // Flush part-way through CALC.
    rdy_force = 1;
    issue(0, 0, 64'd100, 64'd7, wt);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_in_calc", 64'(busy), 64'd1);
    flush = 1'b1;
    void'(sb32.pop_back());
    @(posedge clk);
    #1 flush = 1'b0;
    #1;
    chk("in_ready_after_flush", 64'(in_ready), 64'd1);
    chk("busy_after_flush", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    issue(0, 0, 64'd9, 64'd3, wt);
    drain(0);

    // Stall the consumer in DONE, then release with a back-to-back accept.
    rdy_force = 2;
    issue(0, 1, 64'(-100), 64'd7, wt);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hold_valid_rise", 64'(ok), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("hold_valid", 64'(out_valid), 64'd1);
    end
    rdy_force = 1;
    issue(0, 0, 64'd1000, 64'd10, wt);
    chk("b2b_no_bubble", 64'(wt), 64'd0);
    drain(0);

    // 8-bit instance: directed op, asynchronous reset mid-CALC, then random ops.
    issue(1, 0, 64'd200, 64'd3, wt);
    drain(1);
    issue(1, 0, 64'd77, 64'd5, wt);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst8_n = 1'b0;
    void'(sb8.pop_back());
    #1;
    chk("rst8_out_valid", 64'(ov8), 64'd0);
    chk("rst8_busy", 64'(busy8), 64'd0);
    chk("rst8_quotient", 64'(oq8), 64'd0);
    chk("rst8_remainder", 64'(orm8), 64'd0);
    @(negedge clk);
    rst8_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      issue(1, 1'($urandom_range(0, 1)), rnd_op(8), rnd_op(8), wt);
    end
    issue(1, 1, 64'h80, 64'hFF, wt);
    drain(1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
